// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// Stage entries carry the widest supported register address.
package fwd_pkg;

  localparam int RD_W = 8;
  localparam int CNT_W = 16;
  localparam int SEL_RF = 0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic            v;
    logic [RD_W-1:0] rd;
    logic            ld;
  } stage_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_shadow_pipe.sv
// Shadow pipeline of in-flight register writes, index 0 = stage 1 (EX).
// Flush and reset clear every stage.
module fwd_shadow_pipe
  import fwd_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  stage_t               i_ent,
  output stage_t [DEPTH-1:0]   o_stages
);

  stage_t [DEPTH-1:0] r_pipe;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else if (i_flush) begin
      r_pipe <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_pipe[k] <= r_pipe[k-1];
      end
      r_pipe[0] <= i_ent;
    end
  end

  assign o_stages = r_pipe;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall generation beside decode.
// Nearest matching stage wins; young loads stall instead of forwarding.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 0,
  localparam int SEL_W   = sel_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_we,
  input  logic                      id_load,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  stage_t [DEPTH-1:0] w_stg;
  stage_t             w_ins;
  logic [NUM_SRC-1:0] w_haz;
  logic [CNT_W-1:0]   r_stall_cnt;

  assign w_ins.v  = id_valid & id_we & ~stall;
  assign w_ins.rd = RD_W'(id_rd);
  assign w_ins.ld = id_load;

  fwd_shadow_pipe #(
    .DEPTH(DEPTH)
  ) u_pipe (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .i_ent   (w_ins),
    .o_stages(w_stg)
  );

  always_comb begin
    fwd_sel = '0;
    w_haz   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [REG_AW-1:0] w_src;
      logic              w_can;
      logic              w_hit;
      w_src = id_src[i*REG_AW +: REG_AW];
      w_can = id_valid & id_src_used[i] &
              ~((ZERO_REG != 0) && (w_src == '0));
      w_hit = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (w_can && !w_hit && w_stg[k].v &&
            w_stg[k].rd == RD_W'(w_src)) begin
          w_hit = 1'b1;
          // stage k+1 holds a load whose data is not out yet
          if (k < LOAD_LAT && w_stg[k].ld) begin
            w_haz[i] = 1'b1;
          end else begin
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          end
        end
      end
    end
  end

  assign stall = (|w_haz) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall && r_stall_cnt != CNT_MAX) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
